// File: rtl/id_ex_reg.sv
// ID/EX pipeline register with stall hold, flush bubble injection and a
// saturating bubble counter for performance debug.
module id_ex_reg #(
   parameter int DATA_W = 32,
   parameter int REG_AW = 5,
   parameter int CNT_W  = 16
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              stall_i,
   input  logic              flush_i,
   input  logic              valid_i,
   input  logic              cnt_clr_i,
   input  logic              RegDst_i,
   input  logic [1:0]        ALUOp_i,
   input  logic              ALUSrc_i,
   input  logic              RegWrite_i,
   input  logic              MemToReg_i,
   input  logic              MemRead_i,
   input  logic              MemWrite_i,
   input  logic [DATA_W-1:0] rs_data_i,
   input  logic [DATA_W-1:0] rt_data_i,
   input  logic [DATA_W-1:0] imm_i,
   input  logic [REG_AW-1:0] rs_addr_i,
   input  logic [REG_AW-1:0] rt_addr_i,
   input  logic [REG_AW-1:0] rd_addr_i,
   output logic              RegDst_o,
   output logic [1:0]        ALUOp_o,
   output logic              ALUSrc_o,
   output logic              RegWrite_o,
   output logic              MemToReg_o,
   output logic              MemRead_o,
   output logic              MemWrite_o,
   output logic [DATA_W-1:0] rs_data_o,
   output logic [DATA_W-1:0] rt_data_o,
   output logic [DATA_W-1:0] imm_o,
   output logic [REG_AW-1:0] rs_addr_o,
   output logic [REG_AW-1:0] rt_addr_o,
   output logic [REG_AW-1:0] rd_addr_o,
   output logic              valid_o,
   output logic [CNT_W-1:0]  bubble_cnt_o
);

   logic bubble_s;
   logic ctrlEn_s;
   logic cntSat_s;

   // Classify the coming edge: bubble event and whether control may pass
   always_comb begin
      bubble_s = 1'b0;
      ctrlEn_s = 1'b0;
      if (flush_i) begin
         bubble_s = 1'b1;
      end else if (stall_i) begin
         bubble_s = 1'b0;
      end else begin
         bubble_s = ~valid_i;
         ctrlEn_s = valid_i;
      end
   end

   assign cntSat_s = &bubble_cnt_o;

   // Pipeline register: flush beats stall beats load
   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         RegDst_o   <= 1'b0;
         ALUOp_o    <= 2'b00;
         ALUSrc_o   <= 1'b0;
         RegWrite_o <= 1'b0;
         MemToReg_o <= 1'b0;
         MemRead_o  <= 1'b0;
         MemWrite_o <= 1'b0;
         rs_data_o  <= {DATA_W{1'b0}};
         rt_data_o  <= {DATA_W{1'b0}};
         imm_o      <= {DATA_W{1'b0}};
         rs_addr_o  <= {REG_AW{1'b0}};
         rt_addr_o  <= {REG_AW{1'b0}};
         rd_addr_o  <= {REG_AW{1'b0}};
         valid_o    <= 1'b0;
      end else if (flush_i) begin
         RegDst_o   <= 1'b0;
         ALUOp_o    <= 2'b00;
         ALUSrc_o   <= 1'b0;
         RegWrite_o <= 1'b0;
         MemToReg_o <= 1'b0;
         MemRead_o  <= 1'b0;
         MemWrite_o <= 1'b0;
         rs_data_o  <= {DATA_W{1'b0}};
         rt_data_o  <= {DATA_W{1'b0}};
         imm_o      <= {DATA_W{1'b0}};
         rs_addr_o  <= {REG_AW{1'b0}};
         rt_addr_o  <= {REG_AW{1'b0}};
         rd_addr_o  <= {REG_AW{1'b0}};
         valid_o    <= 1'b0;
      end else if (!stall_i) begin
         // An invalid slot keeps its operands but can never write state
         RegDst_o   <= RegDst_i & ctrlEn_s;
         ALUOp_o    <= ALUOp_i & {2{ctrlEn_s}};
         ALUSrc_o   <= ALUSrc_i & ctrlEn_s;
         RegWrite_o <= RegWrite_i & ctrlEn_s;
         MemToReg_o <= MemToReg_i & ctrlEn_s;
         MemRead_o  <= MemRead_i & ctrlEn_s;
         MemWrite_o <= MemWrite_i & ctrlEn_s;
         rs_data_o  <= rs_data_i;
         rt_data_o  <= rt_data_i;
         imm_o      <= imm_i;
         rs_addr_o  <= rs_addr_i;
         rt_addr_o  <= rt_addr_i;
         rd_addr_o  <= rd_addr_i;
         valid_o    <= valid_i;
      end
   end

   // Saturating bubble counter; clear wins over a simultaneous bubble
   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         bubble_cnt_o <= {CNT_W{1'b0}};
      end else if (cnt_clr_i) begin
         bubble_cnt_o <= {CNT_W{1'b0}};
      end else if (bubble_s && !cntSat_s) begin
         bubble_cnt_o <= bubble_cnt_o + {{(CNT_W-1){1'b0}}, 1'b1};
      end
   end

endmodule

// File: tb/tb_id_ex_reg.sv
// Scoreboard bench for id_ex_reg: the driver pushes expected outputs at each
// edge, a negedge monitor pops and compares them.
module tb_id_ex_reg;

   typedef struct packed {
      logic        regDst;
      logic [1:0]  aluOp;
      logic        aluSrc;
      logic        regWrite;
      logic        memToReg;
      logic        memRead;
      logic        memWrite;
      logic [31:0] rsData;
      logic [31:0] rtData;
      logic [31:0] imm;
      logic [4:0]  rsAddr;
      logic [4:0]  rtAddr;
      logic [4:0]  rdAddr;
      logic        valid;
      logic [15:0] cnt;
   } outT;

   logic clk = 1'b0;
   logic rstN;
   logic stallI, flushI, validI, cntClrI;
   logic regDstI, aluSrcI, regWriteI, memToRegI, memReadI, memWriteI;
   logic [1:0]  aluOpI;
   logic [31:0] rsDataI, rtDataI, immI;
   logic [4:0]  rsAddrI, rtAddrI, rdAddrI;

   logic regDstO, aluSrcO, regWriteO, memToRegO, memReadO, memWriteO, validO;
   logic [1:0]  aluOpO;
   logic [31:0] rsDataO, rtDataO, immO;
   logic [4:0]  rsAddrO, rtAddrO, rdAddrO;
   logic [15:0] cntO;

   outT act;
   outT m;
   outT expQ[$];
   string nameQ[$];
   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   id_ex_reg dut (
      .clk_i(clk), .rst_i(rstN), .stall_i(stallI), .flush_i(flushI),
      .valid_i(validI), .cnt_clr_i(cntClrI),
      .RegDst_i(regDstI), .ALUOp_i(aluOpI), .ALUSrc_i(aluSrcI),
      .RegWrite_i(regWriteI), .MemToReg_i(memToRegI), .MemRead_i(memReadI),
      .MemWrite_i(memWriteI),
      .rs_data_i(rsDataI), .rt_data_i(rtDataI), .imm_i(immI),
      .rs_addr_i(rsAddrI), .rt_addr_i(rtAddrI), .rd_addr_i(rdAddrI),
      .RegDst_o(regDstO), .ALUOp_o(aluOpO), .ALUSrc_o(aluSrcO),
      .RegWrite_o(regWriteO), .MemToReg_o(memToRegO), .MemRead_o(memReadO),
      .MemWrite_o(memWriteO),
      .rs_data_o(rsDataO), .rt_data_o(rtDataO), .imm_o(immO),
      .rs_addr_o(rsAddrO), .rt_addr_o(rtAddrO), .rd_addr_o(rdAddrO),
      .valid_o(validO), .bubble_cnt_o(cntO)
   );

   assign act = {regDstO, aluOpO, aluSrcO, regWriteO, memToRegO, memReadO,
                 memWriteO, rsDataO, rtDataO, immO, rsAddrO, rtAddrO, rdAddrO,
                 validO, cntO};

   task automatic chk(input string name, input logic [135:0] a, input logic [135:0] e);
      checks++;
      if (a !== e) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, a, e);
      end
   endtask

   // Monitor: one output per edge, compared on the falling edge
   always @(negedge clk) begin
      outT e;
      string n;
      if (rstN && expQ.size() > 0) begin
         e = expQ.pop_front();
         n = nameQ.pop_front();
         chk(n, act, e);
      end
   end

   task automatic clearIn();
      stallI = 1'b0; flushI = 1'b0; validI = 1'b0; cntClrI = 1'b0;
      regDstI = 1'b0; aluOpI = 2'b00; aluSrcI = 1'b0; regWriteI = 1'b0;
      memToRegI = 1'b0; memReadI = 1'b0; memWriteI = 1'b0;
      rsDataI = 32'h0; rtDataI = 32'h0; immI = 32'h0;
      rsAddrI = 5'd0; rtAddrI = 5'd0; rdAddrI = 5'd0;
   endtask

   // One clock edge: advance the reference state and queue the expectation
   task automatic step(input string name);
      logic [15:0] c;
      logic bubble;
      @(posedge clk);
      c = m.cnt;
      bubble = flushI || (!stallI && !validI);
      if (flushI) begin
         m = '0;
      end else if (!stallI) begin
         m.regDst   = regDstI & validI;
         m.aluOp    = validI ? aluOpI : 2'b00;
         m.aluSrc   = aluSrcI & validI;
         m.regWrite = regWriteI & validI;
         m.memToReg = memToRegI & validI;
         m.memRead  = memReadI & validI;
         m.memWrite = memWriteI & validI;
         m.rsData = rsDataI; m.rtData = rtDataI; m.imm = immI;
         m.rsAddr = rsAddrI; m.rtAddr = rtAddrI; m.rdAddr = rdAddrI;
         m.valid = validI;
      end
      if (cntClrI) m.cnt = 16'h0;
      else if (bubble && c != 16'hFFFF) m.cnt = c + 16'h1;
      else m.cnt = c;
      expQ.push_back(m);
      nameQ.push_back(name);
      #1;
   endtask

   initial begin
      m = '0;
      clearIn();
      rstN = 1'b0;
      repeat (2) @(negedge clk);
      chk("reset_zero", act, 136'h0);
      rstN = 1'b1;

      // Reset then load
      validI = 1'b1; regWriteI = 1'b1; aluOpI = 2'b10; rsDataI = 32'h0000_0005;
      rdAddrI = 5'd8; rtDataI = 32'hDEAD_BEEF;
      step("load");
      chk("load_regwrite", {135'h0, regWriteO}, 136'h1);
      chk("load_rs", {104'h0, rsDataO}, {104'h0, 32'h5});
      chk("load_rd", {131'h0, rdAddrO}, {131'h0, 5'd8});
      chk("load_cnt", {120'h0, cntO}, 136'h0);

      // Stall hold while inputs change
      stallI = 1'b1; rtDataI = 32'h1;
      repeat (3) step("stall_hold");
      chk("stall_rt", {104'h0, rtDataO}, {104'h0, 32'hDEAD_BEEF});
      stallI = 1'b0;
      step("stall_release");
      chk("release_rt", {104'h0, rtDataO}, {104'h0, 32'h1});

      // Flush wins over stall
      stallI = 1'b1; flushI = 1'b1; memWriteI = 1'b1;
      step("flush_over_stall");
      chk("flush_cnt", {120'h0, cntO}, {120'h0, 16'h1});

      // Invalid load: control gated, data passes
      stallI = 1'b0; flushI = 1'b0; validI = 1'b0; rsDataI = 32'h7;
      step("invalid_load");
      chk("invalid_memwrite", {135'h0, memWriteO}, 136'h0);
      chk("invalid_rs", {104'h0, rsDataO}, {104'h0, 32'h7});
      chk("invalid_cnt", {120'h0, cntO}, {120'h0, 16'h2});

      // Other control and index patterns
      clearIn();
      validI = 1'b1; regDstI = 1'b1; aluSrcI = 1'b1; memToRegI = 1'b1;
      memReadI = 1'b1; aluOpI = 2'b01; immI = 32'hFFFF_FF80;
      rsAddrI = 5'd31; rtAddrI = 5'd17; rdAddrI = 5'd3; rsDataI = 32'hA5A5_0001;
      step("load_misc");
      aluOpI = 2'b11; regDstI = 1'b0; memReadI = 1'b0; memWriteI = 1'b1;
      step("load_misc2");

      // Clear alone, with a real instruction loading
      cntClrI = 1'b1;
      step("clr_only");
      chk("clr_cnt", {120'h0, cntO}, 136'h0);
      cntClrI = 1'b0;

      // Saturation: preload to 0xFFFE, then three more flushes
      clearIn();
      flushI = 1'b1;
      while (m.cnt != 16'hFFFE) step("sat_pre");
      chk("sat_pre_cnt", {120'h0, cntO}, {120'h0, 16'hFFFE});
      repeat (3) step("sat_hold");
      chk("sat_cnt", {120'h0, cntO}, {120'h0, 16'hFFFF});
      cntClrI = 1'b1;
      step("clr_with_flush");
      chk("clr_flush_cnt", {120'h0, cntO}, 136'h0);

      // Async reset between edges
      clearIn();
      validI = 1'b1; regWriteI = 1'b1; rsDataI = 32'h1234_5678; rdAddrI = 5'd9;
      step("pre_reset_load");
      chk("pre_reset_valid", {135'h0, validO}, 136'h1);
      @(negedge clk);
      #1;
      rstN = 1'b0;
      #1;
      chk("async_reset", act, 136'h0);
      m = '0;
      @(posedge clk);
      #1;
      chk("reset_held", act, 136'h0);
      @(negedge clk);
      rstN = 1'b1;
      step("post_reset_load");

      repeat (2) @(negedge clk);
      if (expQ.size() != 0) begin
         checks++;
         errors++;
         $display("FAIL drain: got %0d pending expected 0", expQ.size());
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/id_ex_reg.md
Name: id_ex_reg

Overview:
ID/EX pipeline register of the 5-stage MIPS core. It sits directly downstream of the hazard control-zeroing mux and captures the (possibly bubbled) control bundle and decoded operands at the end of ID. It presents them to EX one cycle later. It supports hold (stall), flush (bubble injection) and a saturating bubble counter for performance debug.

Parameters:
DATA_W, 32, width of register-file operands and sign-extended immediate
REG_AW, 5, register address width
CNT_W, 16, bubble counter width

Ports:
clk_i  in  1  core clock, rising edge
rst_i  in  1  asynchronous reset, active-low (0 = reset)
stall_i  in  1  hold current contents
flush_i  in  1  load a bubble instead of ID contents
valid_i  in  1  ID holds a real instruction
cnt_clr_i  in  1  synchronous clear of bubble counter
RegDst_i  in  1  EX control
ALUOp_i  in  2  EX control
ALUSrc_i  in  1  EX control
RegWrite_i  in  1  WB control
MemToReg_i  in  1  WB control
MemRead_i  in  1  M control
MemWrite_i  in  1  M control
rs_data_i  in  DATA_W  RS read data
rt_data_i  in  DATA_W  RT read data
imm_i  in  DATA_W  sign-extended immediate (funct in [5:0])
rs_addr_i  in  REG_AW  RS index (forwarding)
rt_addr_i  in  REG_AW  RT index (forwarding / load-use)
rd_addr_i  in  REG_AW  RD index
RegDst_o, ALUOp_o, ALUSrc_o, RegWrite_o, MemToReg_o, MemRead_o, MemWrite_o  out  as inputs  registered control
rs_data_o, rt_data_o, imm_o  out  DATA_W  registered operands
rs_addr_o, rt_addr_o, rd_addr_o  out  REG_AW  registered indices
valid_o  out  1  EX slot holds a real instruction
bubble_cnt_o  out  CNT_W  bubbles injected since reset/clear

Behaviour:
- rst_i low, asynchronously: every output goes to 0, including valid_o and bubble_cnt_o. It stays 0 while rst_i is low. On deassertion the first update is at the next rising edge. Reset mid-stall or mid-flush discards the held state.
- Latency is 1 cycle. Inputs sampled at edge N appear on outputs after edge N.
- Per-edge priority is flush_i > stall_i > load.
  - flush_i=1: all control outputs, data and address outputs, and valid_o are set to 0. This applies regardless of stall_i.
  - stall_i=1 (flush_i=0): all outputs hold their values, including valid_o.
  - Otherwise: all fields load from the inputs. valid_o is set to valid_i.
- Gating with valid_i=0 on load: control outputs are forced to 0, so a bubble can never write regfile or memory. Data and address fields still load; they are don't-care for EX.
- Bubble event at an edge: flush_i=1, or a load with valid_i=0. A stalled edge is never a bubble event.
- Counter update per edge:
  - cnt_clr_i=1: counter set to 0. Clear wins over a simultaneous bubble event.
  - Otherwise, on a bubble event: counter increments by 1, saturating at all-ones (0xFFFF for the default CNT_W). It does not wrap.
- No combinational path from any input to any output.

Test Plan:
- Reset then load: rst_i=0 for 2 cycles, release, valid_i=1, RegWrite_i=1, ALUOp_i=2'b10, rs_data_i=32'h0000_0005, rd_addr_i=5'd8 -> after the next edge RegWrite_o=1, ALUOp_o=2'b10, rs_data_o=5, rd_addr_o=8, valid_o=1, bubble_cnt_o=0.
- Stall hold: after loading rt_data_i=32'hDEAD_BEEF, assert stall_i for 3 cycles while changing rt_data_i to 32'h1 -> rt_data_o remains 32'hDEAD_BEEF and bubble_cnt_o is unchanged. After stall_i drops, the next edge gives rt_data_o=32'h1.
- Flush over stall: stall_i=1 and flush_i=1 with MemWrite_i=1, valid_i=1 -> after the edge all outputs are 0 and bubble_cnt_o increments by 1.
- Invalid load gating: valid_i=0, MemWrite_i=1, RegWrite_i=1, rs_data_i=32'h7 -> MemWrite_o=0, RegWrite_o=0, valid_o=0, rs_data_o=7, bubble_cnt_o +1.
- Counter clear and saturation: preload the counter to 0xFFFE via bubbles, then 3 flushes -> bubble_cnt_o reads 0xFFFF and stays there. Then cnt_clr_i=1 with flush_i=1 -> bubble_cnt_o=0.
- Async reset mid-operation: with valid_o=1, pull rst_i low between clock edges -> all outputs are 0 before the next rising edge.
